// File: rtl/alu_result_fifo.sv
// Result-capture stage behind the 4-bit ALU: accumulator feedback register,
// show-ahead history FIFO of {data,flags}, and sticky overflow/drop error bits.
module alu_result_fifo #(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          clr_i,
    input  logic          res_valid_i,
    output logic          res_ready_o,
    input  logic [3:0]    res_data_i,
    input  logic [3:0]    res_flags_i,
    output logic [3:0]    acc_out_o,
    output logic [3:0]    acc_flags_o,
    output logic          rd_valid_o,
    input  logic          rd_pop_i,
    output logic [3:0]    rd_data_o,
    output logic [3:0]    rd_flags_o,
    output logic [CW-1:0] count_o,
    output logic          sticky_v_o,
    output logic          drop_err_o
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    acc_out_q, acc_out_d;
    logic [3:0]    acc_flags_q, acc_flags_d;
    logic          sticky_v_q, sticky_v_d;
    logic          drop_err_q, drop_err_d;
    logic          push_s;
    logic          pop_s;
    logic          wr_en_s;
    logic [7:0]    head_s;

    // Handshake is derived from registered count only, so a pop never opens a full FIFO in the same cycle
    assign res_ready_o = (count_q != CW'(DEPTH));
    assign rd_valid_o  = (count_q != {CW{1'b0}});
    assign push_s      = res_valid_i && res_ready_o;
    assign pop_s       = rd_pop_i && rd_valid_o;
    assign wr_en_s     = push_s && !clr_i;
    assign head_s      = rd_valid_o ? mem_q[rd_ptr_q] : 8'h00;

    assign rd_data_o   = head_s[7:4];
    assign rd_flags_o  = head_s[3:0];
    assign acc_out_o   = acc_out_q;
    assign acc_flags_o = acc_flags_q;
    assign count_o     = count_q;
    assign sticky_v_o  = sticky_v_q;
    assign drop_err_o  = drop_err_q;

    // Next-state logic for pointers, count, accumulator and error bits
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        acc_out_d   = acc_out_q;
        acc_flags_d = acc_flags_q;
        sticky_v_d  = sticky_v_q;
        drop_err_d  = drop_err_q;
        if (clr_i) begin
            wr_ptr_d    = {AW{1'b0}};
            rd_ptr_d    = {AW{1'b0}};
            count_d     = {CW{1'b0}};
            acc_out_d   = 4'h0;
            acc_flags_d = 4'h0;
            sticky_v_d  = 1'b0;
            drop_err_d  = 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_d    = wr_ptr_q + AW'(1);
                acc_out_d   = res_data_i;
                acc_flags_d = res_flags_i;
                sticky_v_d  = sticky_v_q | res_flags_i[0];
            end else if (res_valid_i) begin
                drop_err_d  = 1'b1;
            end else begin
                drop_err_d  = drop_err_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with asynchronous reset
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            count_q     <= {CW{1'b0}};
            acc_out_q   <= 4'h0;
            acc_flags_q <= 4'h0;
            sticky_v_q  <= 1'b0;
            drop_err_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            acc_out_q   <= acc_out_d;
            acc_flags_q <= acc_flags_d;
            sticky_v_q  <= sticky_v_d;
            drop_err_q  <= drop_err_d;
        end
    end

    // History storage; contents survive reset and clear since the pointers define validity
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= {res_data_i, res_flags_i};
        end
    end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed self-checking bench for alu_result_fifo (DEPTH=4).
module tb_alu_result_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       clr;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic [3:0] res_flags;
    logic [3:0] acc_out;
    logic [3:0] acc_flags;
    logic       rd_valid;
    logic       rd_pop;
    logic [3:0] rd_data;
    logic [3:0] rd_flags;
    logic [2:0] count;
    logic       sticky_v;
    logic       drop_err;

    int tests = 0;
    int fails = 0;
    logic [3:0] exp_q [$];
    logic [3:0] exp_v;

    always #5 clk = ~clk;

    alu_result_fifo #(.DEPTH(4)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .clr_i       (clr),
        .res_valid_i (res_valid),
        .res_ready_o (res_ready),
        .res_data_i  (res_data),
        .res_flags_i (res_flags),
        .acc_out_o   (acc_out),
        .acc_flags_o (acc_flags),
        .rd_valid_o  (rd_valid),
        .rd_pop_i    (rd_pop),
        .rd_data_o   (rd_data),
        .rd_flags_o  (rd_flags),
        .count_o     (count),
        .sticky_v_o  (sticky_v),
        .drop_err_o  (drop_err)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_acc"},   8'(acc_out),   8'h0);
        check({tag, "_accf"},  8'(acc_flags), 8'h0);
        check({tag, "_cnt"},   8'(count),     8'h0);
        check({tag, "_rdv"},   8'(rd_valid),  8'h0);
        check({tag, "_rdd"},   8'(rd_data),   8'h0);
        check({tag, "_rdf"},   8'(rd_flags),  8'h0);
        check({tag, "_rdy"},   8'(res_ready), 8'h1);
        check({tag, "_stv"},   8'(sticky_v),  8'h0);
        check({tag, "_drop"},  8'(drop_err),  8'h0);
    endtask

    initial begin
        reset = 1'b1; clr = 1'b0; res_valid = 1'b0; rd_pop = 1'b0;
        res_data = 4'h0; res_flags = 4'h0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        step();
        check_idle("reset");

        // two pushes then drain
        res_valid = 1'b1; res_data = 4'h3; res_flags = 4'b0000;
        step();
        check("push1_rdd", 8'(rd_data), 8'h3);
        res_data = 4'hD; res_flags = 4'b0100;
        step();
        res_valid = 1'b0;
        check("two_acc",  8'(acc_out),   8'hD);
        check("two_accf", 8'(acc_flags), 8'h4);
        check("two_cnt",  8'(count),     8'h2);
        check("two_head", 8'(rd_data),   8'h3);
        check("two_hf",   8'(rd_flags),  8'h0);
        rd_pop = 1'b1;
        step();
        check("pop1_rdd", 8'(rd_data),  8'hD);
        check("pop1_rdf", 8'(rd_flags), 8'h4);
        check("pop1_cnt", 8'(count),    8'h1);
        step();
        check("pop2_rdv", 8'(rd_valid), 8'h0);
        check("pop2_rdd", 8'(rd_data),  8'h0);
        step();
        rd_pop = 1'b0;
        check("popempty_cnt",  8'(count),    8'h0);
        check("popempty_drop", 8'(drop_err), 8'h0);

        // fill to DEPTH then overflow
        res_valid = 1'b1;
        res_data = 4'h1; res_flags = 4'h2; step();
        res_data = 4'h2; res_flags = 4'h4; step();
        res_data = 4'h4; res_flags = 4'h8; step();
        check("fill3_rdy", 8'(res_ready), 8'h1);
        res_data = 4'h8; res_flags = 4'hA; step();
        check("full_rdy",  8'(res_ready), 8'h0);
        check("full_cnt",  8'(count),     8'h4);
        check("full_drop", 8'(drop_err),  8'h0);
        res_data = 4'hF; res_flags = 4'h1; step();
        check("ovf_drop", 8'(drop_err),  8'h1);
        check("ovf_acc",  8'(acc_out),   8'h8);
        check("ovf_accf", 8'(acc_flags), 8'hA);
        check("ovf_stv",  8'(sticky_v),  8'h0);
        check("ovf_cnt",  8'(count),     8'h4);
        check("ovf_head", 8'(rd_data),   8'h1);
        res_data = 4'h6; res_flags = 4'h0; rd_pop = 1'b1;
        step();
        res_valid = 1'b0;
        check("fullpp_cnt", 8'(count),     8'h3);
        check("fullpp_rdy", 8'(res_ready), 8'h1);
        check("fullpp_acc", 8'(acc_out),   8'h8);
        check("fullpp_rdd", 8'(rd_data),   8'h2);
        step();
        check("drain_rdd4", 8'(rd_data), 8'h4);
        step();
        check("drain_rdd8", 8'(rd_data),  8'h8);
        check("drain_rdf8", 8'(rd_flags), 8'hA);
        step();
        rd_pop = 1'b0;
        check("drain_cnt", 8'(count),    8'h0);
        check("drain_drop", 8'(drop_err), 8'h1);
        clr = 1'b1; step(); clr = 1'b0;
        check("clr_drop", 8'(drop_err), 8'h0);

        // steady push+pop at count=2 across pointer wrap
        res_valid = 1'b1;
        res_data = 4'h5; res_flags = 4'h0; step(); exp_q.push_back(4'h5);
        res_data = 4'h6; step(); exp_q.push_back(4'h6);
        rd_pop = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_v = 4'(i + 7);
            res_data = exp_v;
            check("pp_head", 8'(rd_data), 8'(exp_q.pop_front()));
            exp_q.push_back(exp_v);
            step();
            check("pp_cnt", 8'(count), 8'h2);
        end
        res_valid = 1'b0;
        check("pp_tail0", 8'(rd_data), 8'(exp_q.pop_front()));
        step();
        check("pp_tail1", 8'(rd_data), 8'(exp_q.pop_front()));
        step();
        rd_pop = 1'b0;
        check("pp_empty", 8'(rd_valid), 8'h0);

        // sticky V and clear-with-push
        res_valid = 1'b1; res_data = 4'h7; res_flags = 4'b0001; step();
        check("v1_stv", 8'(sticky_v), 8'h1);
        res_data = 4'h2; res_flags = 4'b0000; step();
        check("v0_stv", 8'(sticky_v), 8'h1);
        check("v0_acc", 8'(acc_out),  8'h2);
        check("v0_cnt", 8'(count),    8'h2);
        clr = 1'b1; res_data = 4'h9; res_flags = 4'b0001; step();
        clr = 1'b0; res_valid = 1'b0;
        check_idle("clrpush");

        // asynchronous reset between edges
        res_valid = 1'b1; res_flags = 4'b0000;
        res_data = 4'hA; step();
        res_data = 4'hB; step();
        res_data = 4'hC; step();
        res_valid = 1'b0;
        check("pre_rst_cnt", 8'(count), 8'h3);
        #2 reset = 1'b1;
        #1;
        check_idle("async_rst");
        #2 reset = 1'b0;
        step();
        check_idle("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_result_fifo.md
# alu_result_fifo

Result-capture stage directly downstream of the 4-bit ALU. Each strobed ALU result (4-bit signed value plus Z/N/C/V flags) is latched into an accumulator register, which drives back to the ALU A operand for chained operations. The same result is also pushed into a small show-ahead history FIFO that the display/readout logic drains one entry at a time. Sticky error bits record V-overflow and dropped results until cleared.

## Interface
Parameters:
- DEPTH, 4: history FIFO entries; power of two, minimum 2.
- CW, $clog2(DEPTH+1): width of `count` (derived, not overridden).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear of all state.
- res_valid  input  1  ALU result strobe.
- res_ready  output  1  high when a push will be accepted.
- res_data  input  4  signed ALU result.
- res_flags  input  4  {Z,N,C,V} as produced with `res_data`.
- acc_out  output  4  last accepted result; feeds ALU A operand.
- acc_flags  output  4  flags of last accepted result.
- rd_valid  output  1  FIFO non-empty.
- rd_pop  input  1  consume head entry.
- rd_data  output  4  head entry value (show-ahead).
- rd_flags  output  4  head entry flags.
- count  output  CW  entries held, 0..DEPTH.
- sticky_v  output  1  an accepted result had V=1 since last clear.
- drop_err  output  1  a strobe arrived while `res_ready` was low.

## Operation
- Push accepted iff `res_valid && res_ready`; `res_ready = (count != DEPTH)`, combinational from registered count only. `res_ready` does not depend on `rd_pop`.
- On accept:
  - `{res_data,res_flags}` is written at the write pointer, which advances.
  - `acc_out <= res_data`, `acc_flags <= res_flags`.
  - `sticky_v <= sticky_v | res_flags[0]`.
- `res_valid && !res_ready`: the data is discarded and `drop_err <= 1`. The accumulator is not updated and `sticky_v` is unaffected.
- Pop is effective iff `rd_pop && rd_valid`; the read pointer advances. Pop while empty is ignored and sets no error.
- `rd_valid = (count != 0)`. `rd_data`/`rd_flags` present the head entry combinationally from storage. Both read 0 when empty (gated).
- Push and pop in the same cycle with 0 < count < DEPTH: count unchanged, both pointers advance.
- When full, a simultaneous push and pop results in the pop only; the push counts as a drop (`drop_err` set).
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH naturally. Count is tracked separately to distinguish full from empty.
- `clr` has priority over push and pop in the same cycle. It zeroes both pointers, `count`, `acc_out`, `acc_flags`, `sticky_v` and `drop_err`. Storage contents need not be cleared.
- No arithmetic is performed on data; values pass through bit-exact.

## Timing
- Reset (async assert, sync release by the caller): pointers 0, count 0, acc_out 0, acc_flags 0, sticky_v 0, drop_err 0. This gives rd_valid 0, rd_data 0, rd_flags 0, res_ready 1.
- Push latency: entry visible on rd_data/rd_valid the cycle after the accepting edge.
- acc_out/acc_flags update on the accepting edge, visible the next cycle.
- Pop: the next head appears the cycle after the popping edge.
- res_ready falls the cycle after the push that fills the FIFO, and rises the cycle after the first pop from full.
- Reset asserted mid-operation forces all registers to reset values immediately, independent of clk.

## Test plan
- Reset then idle: verify acc_out=0, count=0, rd_valid=0, res_ready=1, sticky_v=0, drop_err=0.
- Push 4'h3 flags 4'b0000, then 4'hD flags 4'b0100:
  - acc_out=D, count=2.
  - rd_data=3; pop → rd_data=D; pop → rd_valid=0.
- Push 5 values with DEPTH=4:
  - res_ready low after 4th push; 5th strobe sets drop_err=1.
  - Contents read back are the first 4 only, in order.
  - acc_out equals the 4th value.
- At count=2, push and pop in the same cycle for 10 consecutive cycles (pointer wrap): count stays 2 and the pop order equals the push order.
- Push with V=1, then push with V=0: sticky_v stays 1. Assert clr together with a push: all state zero the next cycle and the push is lost.
- Assert reset asynchronously between edges while count=3: outputs hit reset values before the next clk edge.
